// File: rtl/cv32e40p_ex_stage_mc.sv
// Execute stage: single-cycle ALU, optional iterative shift-add multiplier, EX/WB pipeline register.
// Define CV32E40P_EX_MUL_EN to build the multi-cycle multiplier; otherwise MUL completes with wb_err_o=1.
module cv32e40p_ex_stage_mc #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] operand_a_i,
    input  logic [DATA_W-1:0] operand_b_i,
    input  logic [DATA_W-1:0] operand_c_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              id_valid_i,
    output logic              ex_ready_o,
    input  logic              flush_i,
    output logic              branch_decision_o,
    output logic [DATA_W-1:0] jump_target_o,
    output logic              fw_we_o,
    output logic [ADDR_W-1:0] fw_waddr_o,
    output logic [DATA_W-1:0] fw_wdata_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic              wb_err_o
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic              r_wb_valid;
    logic              r_wb_we;
    logic [ADDR_W-1:0] r_wb_waddr;
    logic [DATA_W-1:0] r_wb_wdata;
    logic              r_wb_err;

    logic [DATA_W-1:0] w_sc_result;
    logic              w_wb_free;
    logic              w_is_mul;
    logic              w_accept;
    logic              w_wr;
    logic              w_wr_we;
    logic [ADDR_W-1:0] w_wr_waddr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_wr_err;

    always_comb begin
        w_sc_result = '0;
        case (op_i)
            OP_ADD:  w_sc_result = operand_a_i + operand_b_i;
            OP_SUB:  w_sc_result = operand_a_i - operand_b_i;
            OP_AND:  w_sc_result = operand_a_i & operand_b_i;
            OP_OR:   w_sc_result = operand_a_i | operand_b_i;
            OP_XOR:  w_sc_result = operand_a_i ^ operand_b_i;
            OP_SLTU: w_sc_result = {{(DATA_W-1){1'b0}}, (operand_a_i < operand_b_i)};
            OP_PASS: w_sc_result = operand_c_i;
            default: w_sc_result = '0;
        endcase
    end

    assign w_wb_free = !r_wb_valid || wb_ready_i;
    assign w_is_mul  = (op_i == OP_MUL);
    assign w_accept  = id_valid_i && ex_ready_o;

`ifdef CV32E40P_EX_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic              r_mul_we;
    logic [ADDR_W-1:0] r_mul_waddr;
    logic              w_mul_wr;

    assign ex_ready_o = (r_state == IDLE) && w_wb_free && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mul_wr     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_mul) w_state_next = MUL_BUSY;
            end
            MUL_BUSY: begin
                if (flush_i)                w_state_next = IDLE;
                else if (r_cnt == CNT_LAST) w_state_next = MUL_DONE;
            end
            MUL_DONE: begin
                if (flush_i) begin
                    w_state_next = IDLE;
                end else if (w_wb_free) begin
                    w_mul_wr     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Only the low DATA_W product bits are kept, so the multiplicand may shift out freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_mul_we    <= 1'b0;
            r_mul_waddr <= '0;
        end else if (w_accept && w_is_mul) begin
            r_cnt       <= '0;
            r_mcand     <= operand_a_i;
            r_mplier    <= operand_b_i;
            r_acc       <= '0;
            r_mul_we    <= we_i;
            r_mul_waddr <= waddr_i;
        end else if (r_state == MUL_BUSY) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_ONE;
        end
    end

    assign w_wr       = (w_accept && !w_is_mul) || w_mul_wr;
    assign w_wr_we    = w_mul_wr ? r_mul_we    : we_i;
    assign w_wr_waddr = w_mul_wr ? r_mul_waddr : waddr_i;
    assign w_wr_data  = w_mul_wr ? r_acc       : w_sc_result;
    assign w_wr_err   = 1'b0;
`else
    // Without the multiplier MUL is retired immediately as an error with a zero result.
    assign ex_ready_o = w_wb_free && !flush_i;
    assign w_wr       = w_accept;
    assign w_wr_we    = we_i;
    assign w_wr_waddr = waddr_i;
    assign w_wr_data  = w_sc_result;
    assign w_wr_err   = w_is_mul;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_waddr <= '0;
            r_wb_wdata <= '0;
            r_wb_err   <= 1'b0;
        end else if (w_wr) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= w_wr_we;
            r_wb_wdata <= w_wr_data;
            r_wb_err   <= w_wr_err;
            if (w_wr_we) r_wb_waddr <= w_wr_waddr;
        end else if (wb_ready_i) begin
            r_wb_valid <= 1'b0;
        end
    end

    assign branch_decision_o = (operand_a_i == operand_b_i);
    assign jump_target_o     = operand_c_i;
    assign fw_we_o           = w_accept && we_i && !w_is_mul;
    assign fw_waddr_o        = waddr_i;
    assign fw_wdata_o        = w_sc_result;

    assign wb_valid_o = r_wb_valid;
    assign wb_we_o    = r_wb_we;
    assign wb_waddr_o = r_wb_waddr;
    assign wb_wdata_o = r_wb_wdata;
    assign wb_err_o   = r_wb_err;

endmodule

// File: tb/tb_cv32e40p_ex_stage_mc.sv
// Self-checking bench for cv32e40p_ex_stage_mc: directed scenarios plus randomized traffic
// against a transaction-level model of the EX/WB register. Follows CV32E40P_EX_MUL_EN.
module tb_cv32e40p_ex_stage_mc;
    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    op_i;
    logic [DW-1:0] operand_a_i, operand_b_i, operand_c_i;
    logic          we_i;
    logic [AW-1:0] waddr_i;
    logic          id_valid_i;
    logic          ex_ready_o;
    logic          flush_i;
    logic          branch_decision_o;
    logic [DW-1:0] jump_target_o;
    logic          fw_we_o;
    logic [AW-1:0] fw_waddr_o;
    logic [DW-1:0] fw_wdata_o;
    logic          wb_valid_o;
    logic          wb_ready_i;
    logic          wb_we_o;
    logic [AW-1:0] wb_waddr_o;
    logic [DW-1:0] wb_wdata_o;
    logic          wb_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cv32e40p_ex_stage_mc #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .op_i(op_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operand_c_i(operand_c_i),
        .we_i(we_i), .waddr_i(waddr_i), .id_valid_i(id_valid_i), .ex_ready_o(ex_ready_o),
        .flush_i(flush_i), .branch_decision_o(branch_decision_o), .jump_target_o(jump_target_o),
        .fw_we_o(fw_we_o), .fw_waddr_o(fw_waddr_o), .fw_wdata_o(fw_wdata_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_we_o(wb_we_o),
        .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o), .wb_err_o(wb_err_o)
    );

    // Architectural meaning of each opcode, results wrap modulo 2^DW.
    function automatic logic [DW-1:0] ref_result(input logic [2:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b, input logic [DW-1:0] c);
        logic [2*DW-1:0] p;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (a < b) ? 32'd1 : 32'd0;
            3'd6: begin
`ifdef CV32E40P_EX_MUL_EN
                p = {32'd0, a} * {32'd0, b};
                return p[DW-1:0];
`else
                p = '0;
                return p[DW-1:0];
`endif
            end
            default: return c;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic we, input logic [AW-1:0] wa,
                         input logic vld);
        op_i = op; operand_a_i = a; operand_b_i = b; operand_c_i = c;
        we_i = we; waddr_i = wa; id_valid_i = vld;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1;
        drive(3'd0, '0, '0, '0, 1'b0, '0, 1'b0);
        #2;
        n_tests++; if ({wb_valid_o, wb_we_o, wb_err_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {wb_valid_o, wb_we_o, wb_err_o}); end
        n_tests++; if ({wb_waddr_o, wb_wdata_o} !== '0) begin n_fail++; $display("FAIL reset_data got=%h/%h exp=0/0", wb_waddr_o, wb_wdata_o); end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ex_ready_o); end
        $display("[TB] reset released");
    endtask

    task automatic test_add_wrap();
        wb_ready_i = 1'b1;
        drive(3'd0, 32'hFFFF_FFFF, 32'd1, 32'h1234_5678, 1'b1, 6'd5, 1'b1);
        #1;
        n_tests++; if ({fw_we_o, fw_waddr_o, fw_wdata_o} !== {1'b1, 6'd5, 32'd0}) begin n_fail++; $display("FAIL add_fw got=%b/%0d/%h exp=1/5/0", fw_we_o, fw_waddr_o, fw_wdata_o); end
        n_tests++; if (jump_target_o !== 32'h1234_5678) begin n_fail++; $display("FAIL add_jump got=%h exp=12345678", jump_target_o); end
        tick();
        id_valid_i = 1'b0;
        n_tests++; if ({wb_valid_o, wb_we_o, wb_err_o, wb_waddr_o, wb_wdata_o} !== {3'b110, 6'd5, 32'd0}) begin n_fail++; $display("FAIL add_wb got=%b%b%b/%0d/%h exp=110/5/0", wb_valid_o, wb_we_o, wb_err_o, wb_waddr_o, wb_wdata_o); end
        tick();
        n_tests++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL add_consume got=%b exp=0", wb_valid_o); end
        $display("[TB] txn ADD ffffffff+1 -> wb 0 @r5");
    endtask

    task automatic test_sltu_stall();
        wb_ready_i = 1'b0;
        drive(3'd5, 32'd3, 32'd5, '0, 1'b1, 6'd9, 1'b1);
        tick();
        drive(3'd0, 32'd1, 32'd1, '0, 1'b1, 6'd10, 1'b1);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if ({wb_valid_o, wb_waddr_o, wb_wdata_o} !== {1'b1, 6'd9, 32'd1}) begin n_fail++; $display("FAIL sltu_hold%0d got=%b/%0d/%h exp=1/9/1", i, wb_valid_o, wb_waddr_o, wb_wdata_o); end
            n_tests++; if (ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL sltu_ready%0d got=%b exp=0", i, ex_ready_o); end
            tick();
        end
        wb_ready_i = 1'b1;
        #1;
        n_tests++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL sltu_release got=%b exp=1", ex_ready_o); end
        tick();
        id_valid_i = 1'b0;
        n_tests++; if ({wb_valid_o, wb_waddr_o, wb_wdata_o} !== {1'b1, 6'd10, 32'd2}) begin n_fail++; $display("FAIL sltu_swap got=%b/%0d/%h exp=1/10/2", wb_valid_o, wb_waddr_o, wb_wdata_o); end
        tick();
        $display("[TB] txn SLTU 3<5 held 4 cycles, then ADD 1+1 replaced it");
    endtask

    task automatic test_back_to_back();
        logic [2:0]    ops [3] = '{3'd0, 3'd4, 3'd1};
        logic [DW-1:0] as  [3] = '{32'd10, 32'hF0, 32'd5};
        logic [DW-1:0] bs  [3] = '{32'd20, 32'hFF, 32'd7};
        logic          wes [3] = '{1'b1, 1'b0, 1'b1};
        logic [AW-1:0] was [3] = '{6'd7, 6'd12, 6'd3};
        logic [AW-1:0] exa [3] = '{6'd7, 6'd7, 6'd3};
        logic [DW-1:0] exp_d;
        wb_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], as[i], bs[i], '0, wes[i], was[i], 1'b1);
            exp_d = ref_result(ops[i], as[i], bs[i], '0);
            tick();
            n_tests++; if ({wb_valid_o, wb_we_o, wb_waddr_o, wb_wdata_o} !== {1'b1, wes[i], exa[i], exp_d}) begin n_fail++; $display("FAIL b2b%0d got=%b%b/%0d/%h exp=1%b/%0d/%h", i, wb_valid_o, wb_we_o, wb_waddr_o, wb_wdata_o, wes[i], exa[i], exp_d); end
            $display("[TB] txn b2b op=%0d a=%h b=%h -> %h", ops[i], as[i], bs[i], exp_d);
        end
        id_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        wb_ready_i = 1'b1; flush_i = 1'b1;
        drive(3'd3, 32'h0F, 32'hF0, '0, 1'b1, 6'd1, 1'b1);
        #1;
        n_tests++; if ({ex_ready_o, fw_we_o} !== 2'b00) begin n_fail++; $display("FAIL flush_block got=%b%b exp=00", ex_ready_o, fw_we_o); end
        tick();
        n_tests++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_nowrite got=%b exp=0", wb_valid_o); end
        flush_i = 1'b0; wb_ready_i = 1'b0;
        tick();
        drive(3'd0, '0, '0, '0, 1'b0, '0, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_tests++; if ({wb_valid_o, wb_wdata_o} !== {1'b1, 32'hFF}) begin n_fail++; $display("FAIL flush_keep got=%b/%h exp=1/ff", wb_valid_o, wb_wdata_o); end
        wb_ready_i = 1'b1;
        tick();
        $display("[TB] txn OR 0f|f0 blocked by flush, then kept across flush");
    endtask

    task automatic test_async_reset();
        wb_ready_i = 1'b0;
        drive(3'd7, '0, '0, 32'hDEAD_BEEF, 1'b1, 6'd33, 1'b1);
        tick();
        id_valid_i = 1'b0;
        n_tests++; if ({wb_valid_o, wb_wdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL pass_wb got=%b/%h exp=1/deadbeef", wb_valid_o, wb_wdata_o); end
`ifdef CV32E40P_EX_MUL_EN
        wb_ready_i = 1'b1;
        drive(3'd6, 32'd3, 32'd4, '0, 1'b1, 6'd8, 1'b1);
        tick();
        id_valid_i = 1'b0;
        repeat (5) tick();
`endif
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if ({wb_valid_o, wb_we_o, wb_err_o, wb_waddr_o, wb_wdata_o} !== '0) begin n_fail++; $display("FAIL async_rst got=%b%b%b/%h/%h exp=0", wb_valid_o, wb_we_o, wb_err_o, wb_waddr_o, wb_wdata_o); end
        tick();
        rst_n = 1'b1; wb_ready_i = 1'b1;
        #1;
        n_tests++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", ex_ready_o); end
        begin
            int seen = 0;
            repeat (40) begin tick(); if (wb_valid_o) seen++; end
            n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_discard got=%0d valid cycles exp=0", seen); end
        end
        $display("[TB] async reset mid-operation");
    endtask

`ifdef CV32E40P_EX_MUL_EN
    task automatic test_mul();
        logic [DW-1:0] ma [2] = '{32'd7, 32'h10000};
        logic [DW-1:0] mb [2] = '{32'd9, 32'h10000};
        logic [DW-1:0] exp_d;
        int n, seen;
        wb_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_d = ref_result(3'd6, ma[k], mb[k], '0);
            drive(3'd6, ma[k], mb[k], '0, 1'b1, AW'(20 + k), 1'b1);
            #1;
            n_tests++; if ({ex_ready_o, fw_we_o} !== 2'b10) begin n_fail++; $display("FAIL mul_accept%0d got=%b%b exp=10", k, ex_ready_o, fw_we_o); end
            tick();
            id_valid_i = 1'b0;
            n = 0; seen = 0;
            while (!ex_ready_o && n < 100) begin if (wb_valid_o) seen++; n++; tick(); end
            n_tests++; if (n != DW + 1) begin n_fail++; $display("FAIL mul_busy%0d got=%0d exp=%0d", k, n, DW + 1); end
            n_tests++; if (seen != 0) begin n_fail++; $display("FAIL mul_early%0d got=%0d exp=0", k, seen); end
            n_tests++; if ({wb_valid_o, wb_waddr_o, wb_wdata_o} !== {1'b1, AW'(20 + k), exp_d}) begin n_fail++; $display("FAIL mul_res%0d got=%b/%0d/%h exp=1/%0d/%h", k, wb_valid_o, wb_waddr_o, wb_wdata_o, 20 + k, exp_d); end
            $display("[TB] txn MUL %h*%h -> %h", ma[k], mb[k], exp_d);
            tick();
        end
    endtask

    task automatic test_mul_flush();
        int seen = 0;
        wb_ready_i = 1'b1;
        drive(3'd6, 32'd123, 32'd456, '0, 1'b1, 6'd2, 1'b1);
        tick();
        id_valid_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        #1;
        n_tests++; if (ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL mflush_ready got=%b exp=0", ex_ready_o); end
        tick();
        flush_i = 1'b0;
        #1;
        n_tests++; if ({ex_ready_o, wb_valid_o} !== 2'b10) begin n_fail++; $display("FAIL mflush_idle got=%b%b exp=10", ex_ready_o, wb_valid_o); end
        repeat (40) begin tick(); if (wb_valid_o) seen++; end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL mflush_nowrite got=%0d exp=0", seen); end
        $display("[TB] txn MUL 123*456 flushed at cycle 10");
    endtask

    task automatic test_mul_stall();
        int n = 0;
        wb_ready_i = 1'b0;
        drive(3'd6, 32'd11, 32'd13, '0, 1'b1, 6'd14, 1'b1);
        tick();
        id_valid_i = 1'b0;
        while (!wb_valid_o && n < 100) begin n++; tick(); end
        n_tests++; if (n != DW + 1) begin n_fail++; $display("FAIL mstall_lat got=%0d exp=%0d", n, DW + 1); end
        repeat (3) begin
            n_tests++; if ({ex_ready_o, wb_valid_o, wb_wdata_o} !== {2'b01, 32'd143}) begin n_fail++; $display("FAIL mstall_hold got=%b%b/%h exp=01/8f", ex_ready_o, wb_valid_o, wb_wdata_o); end
            tick();
        end
        wb_ready_i = 1'b1;
        #1;
        n_tests++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL mstall_release got=%b exp=1", ex_ready_o); end
        tick();
        n_tests++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL mstall_consume got=%b exp=0", wb_valid_o); end
        $display("[TB] txn MUL 11*13 -> 8f under back-pressure");
    endtask
`else
    task automatic test_mul_disabled();
        wb_ready_i = 1'b1;
        drive(3'd6, 32'd7, 32'd9, '0, 1'b1, 6'd4, 1'b1);
        #1;
        n_tests++; if ({ex_ready_o, fw_we_o} !== 2'b10) begin n_fail++; $display("FAIL mdis_accept got=%b%b exp=10", ex_ready_o, fw_we_o); end
        tick();
        id_valid_i = 1'b0;
        n_tests++; if ({wb_valid_o, wb_err_o, wb_we_o, wb_waddr_o, wb_wdata_o} !== {3'b111, 6'd4, 32'd0}) begin n_fail++; $display("FAIL mdis_wb got=%b%b%b/%0d/%h exp=111/4/0", wb_valid_o, wb_err_o, wb_we_o, wb_waddr_o, wb_wdata_o); end
        n_tests++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL mdis_idle got=%b exp=1", ex_ready_o); end
        tick();
        $display("[TB] txn MUL 7*9 disabled -> err");
    endtask
`endif

    task automatic test_random();
        logic          m_valid = 1'b0, m_we = 1'b0, m_err = 1'b0;
        logic [AW-1:0] m_waddr = '0;
        logic [DW-1:0] m_data = '0;
        logic [2:0]    op;
        logic [DW-1:0] a, b, c, r;
        logic          vld, we, exp_ready, acc;
        logic [AW-1:0] wa;
        for (int cyc = 0; cyc < 200; cyc++) begin
            op = 3'($urandom_range(0, 7));
`ifdef CV32E40P_EX_MUL_EN
            if (op == 3'd6) op = 3'd7;
`endif
            a = $urandom; b = $urandom; c = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = '1;
                2: b = '0;
                default: ;
            endcase
            vld = ($urandom_range(0, 9) < 7);
            we  = 1'($urandom_range(0, 1));
            wa  = AW'($urandom_range(0, 63));
            wb_ready_i = ($urandom_range(0, 9) < 6);
            flush_i    = ($urandom_range(0, 9) == 0);
            drive(op, a, b, c, we, wa, vld);
            #1;
            r = ref_result(op, a, b, c);
            exp_ready = (!m_valid || wb_ready_i) && !flush_i;
            acc = vld && exp_ready;
            n_tests++; if (ex_ready_o !== exp_ready) begin n_fail++; $display("FAIL rnd_ready@%0d got=%b exp=%b", cyc, ex_ready_o, exp_ready); end
            n_tests++; if ({fw_we_o, fw_waddr_o} !== {acc && we && (op != 3'd6), wa}) begin n_fail++; $display("FAIL rnd_fw@%0d got=%b/%0d exp=%b/%0d", cyc, fw_we_o, fw_waddr_o, acc && we && (op != 3'd6), wa); end
            if (op != 3'd6) begin
                n_tests++; if (fw_wdata_o !== r) begin n_fail++; $display("FAIL rnd_fwdata@%0d op=%0d got=%h exp=%h", cyc, op, fw_wdata_o, r); end
            end
            n_tests++; if ({branch_decision_o, jump_target_o} !== {a == b, c}) begin n_fail++; $display("FAIL rnd_branch@%0d got=%b/%h exp=%b/%h", cyc, branch_decision_o, jump_target_o, a == b, c); end
            tick();
            if (acc) begin
                m_valid = 1'b1; m_we = we; m_data = r; m_err = (op == 3'd6);
                if (we) m_waddr = wa;
                $display("[TB] txn rnd op=%0d a=%h b=%h c=%h we=%b rd=%0d -> %h", op, a, b, c, we, wa, r);
            end else if (wb_ready_i) begin
                m_valid = 1'b0;
            end
            n_tests++; if (wb_valid_o !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d got=%b exp=%b", cyc, wb_valid_o, m_valid); end
            if (m_valid) begin
                n_tests++; if ({wb_we_o, wb_err_o, wb_wdata_o} !== {m_we, m_err, m_data}) begin n_fail++; $display("FAIL rnd_wb@%0d got=%b%b/%h exp=%b%b/%h", cyc, wb_we_o, wb_err_o, wb_wdata_o, m_we, m_err, m_data); end
                if (m_we) begin
                    n_tests++; if (wb_waddr_o !== m_waddr) begin n_fail++; $display("FAIL rnd_waddr@%0d got=%0d exp=%0d", cyc, wb_waddr_o, m_waddr); end
                end
            end
        end
        id_valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sltu_stall();
        test_back_to_back();
        test_flush();
`ifdef CV32E40P_EX_MUL_EN
        test_mul();
        test_mul_flush();
        test_mul_stall();
`else
        test_mul_disabled();
`endif
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cv32e40p_ex_stage_mc.md
CV32E40P_EX_STAGE_MC -- requirements
Module: cv32e40p_ex_stage_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width (legal: 8..64, even).
REQ-002 SHALL have parameter ADDR_W, default 6, register-file write address width.
REQ-003 SHALL have one clock and an asynchronous active-low reset, named as the codebase does:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have these data, control and handshake ports:
- op_i  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLTU, 110 MUL, 111 PASS (result = operand_c_i).
- operand_a_i, operand_b_i, operand_c_i  in  DATA_W  operands.
- we_i  in  1  instruction writes the register file.
- waddr_i  in  ADDR_W  destination register.
- id_valid_i  in  1  ID presents an instruction.
- ex_ready_o  out  1  EX accepts the instruction this cycle.
- flush_i  in  1  kill any EX in-flight instruction.
- branch_decision_o  out  1  operand_a_i == operand_b_i, combinational.
- jump_target_o  out  DATA_W  operand_c_i, combinational.
- fw_we_o, fw_waddr_o, fw_wdata_o  out  1/ADDR_W/DATA_W  forwarding of the single-cycle result.
- wb_valid_o  out  1  EX/WB register holds a result.
- wb_ready_i  in  1  WB consumes the result.
- wb_we_o, wb_waddr_o, wb_wdata_o, wb_err_o  out  1/ADDR_W/DATA_W/1  EX/WB register contents.

Function
REQ-005 An instruction SHALL be accepted on a rising edge where id_valid_i && ex_ready_o.
REQ-006 ex_ready_o SHALL equal (state==IDLE) && (!wb_valid_o || wb_ready_i) && !flush_i.
REQ-007 Single-cycle ops (all except MUL) SHALL be written to the EX/WB register on the accept edge; wb_valid_o is high the next cycle (latency 1).
- Results are modulo 2^DATA_W.
- SLTU result is zero-extended 1/0.
REQ-008 The FSM SHALL have states IDLE, MUL_BUSY and MUL_DONE.
- IDLE -> MUL_BUSY on MUL accept; operands and waddr/we are captured and the iteration counter is cleared.
- MUL_BUSY: one shift-add step per cycle; -> MUL_DONE on the edge completing step DATA_W-1.
- MUL_DONE: writes the low DATA_W bits of the product to EX/WB on the first edge where !wb_valid_o || wb_ready_i, then -> IDLE.
REQ-009 For an unstalled MUL accepted at edge E, wb_valid_o SHALL rise after edge E+DATA_W+1.
REQ-010 flush_i SHALL force MUL_BUSY/MUL_DONE to IDLE on that edge with no EX/WB write; it SHALL NOT clear a result already in EX/WB.
REQ-011 flush_i SHALL block acceptance in the same cycle.
REQ-012 EX/WB SHALL hold its value while wb_valid_o && !wb_ready_i.
- On a wb_ready_i edge with no new write, wb_valid_o clears next cycle.
- A simultaneous consume and new write SHALL keep wb_valid_o high with the new data.
REQ-013 fw_we_o SHALL be id_valid_i && ex_ready_o && we_i && op_i!=MUL.
- fw_wdata_o is the combinational single-cycle result.
- fw_waddr_o = waddr_i.
REQ-014 wb_we_o SHALL be meaningful only while wb_valid_o; wb_waddr_o updates only when the written we is 1.

Reset
REQ-015 On rst_n low, regardless of clock, the following SHALL be set:
- state = IDLE, counter = 0.
- wb_valid_o, wb_we_o, wb_err_o = 0.
- wb_waddr_o, wb_wdata_o = 0.
REQ-016 A reset mid-MUL SHALL discard the operation; ex_ready_o is 1 in the first cycle after release.

Configuration
REQ-017 Macro CV32E40P_EX_MUL_EN SHALL control the multiplier.
- Defined: MUL is implemented per REQ-008/009.
- Undefined: no FSM datapath or counter logic; MUL completes as a single-cycle op with result 0 and wb_err_o=1; the state never leaves IDLE.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ADD 0xFFFFFFFF + 1, we=1, waddr=5, wb_ready_i=1 -> next cycle wb_valid_o=1, wb_wdata_o=0, wb_waddr_o=5; fw_wdata_o=0 in the accept cycle.
- MUL 7 x 9 (MUL_EN) with wb_ready_i=1 -> ex_ready_o=0 for 33 cycles, then wb_wdata_o=63; MUL 0x10000 x 0x10000 -> 0.
- SLTU 3,5 with wb_ready_i=0 for 4 cycles -> wb_wdata_o=1 held stable, ex_ready_o=0 until wb_ready_i=1.
- MUL accepted, flush_i at cycle 10 -> no wb_valid_o rise, ex_ready_o=1 the next cycle.
- MUL done while EX/WB full, wb_ready_i=0 -> stays in MUL_DONE; wb_ready_i=1 -> product written the next edge.
- rst_n low during MUL_BUSY -> all outputs 0 immediately; MUL_EN undefined -> MUL gives wb_err_o=1, wb_wdata_o=0.
